hamming_secded_encoder_pipe: RTL and testbench
==============================================

Name: hamming_secded_encoder_pipe

Overview:
Parametrised SECDED Hamming encoder with a valid/ready stream interface, 1- or 2-stage pipelining, per-word error-injection mask and an encoded-word counter. It is the successor to the fixed 11-bit, 2048-entry lookup-table encoder. Parity is computed arithmetically for any data width. It sits between the data source and the channel/storage model and feeds the matching SECDED decoder. Error injection lets decoder benches be driven directly.

Parameters:
DATA_W, 11, data word width in bits (min 4, max 57).
PAR_W, derived, Hamming check bits: smallest r with 2^r >= DATA_W + r + 1 (4 for DATA_W=11).
CW_W, derived, codeword width = DATA_W + PAR_W + 1 (16 for DATA_W=11).
PIPE, 1, pipeline depth in register stages (1 or 2).
CNT_W, 16, width of the encoded-word counter.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  encoder can accept a word this cycle
in_data  in  DATA_W  data word
in_inj_mask  in  CW_W  XOR mask applied to the codeword; all zero = clean
out_valid  out  1  codeword valid
out_ready  in  1  downstream accepts the codeword
out_code  out  CW_W  encoded codeword (after mask)
enc_count  out  CNT_W  count of codewords handed off downstream

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0: out_valid=0, out_code=0, enc_count=0, all stage valids cleared. in_ready=1 from the first cycle after release.
- Codeword layout, positions 0..CW_W-1:
  - Position 0 is overall even parity: XOR of positions 1..CW_W-1.
  - Power-of-two positions 1, 2, 4, ... hold check bits c0..c(PAR_W-1).
  - Remaining positions hold data bits in ascending order, in_data[0] lowest. For DATA_W=11 this puts d0 at position 3, d3 at 7, d4 at 9 and d10 at 15.
- Check bits: the PAR_W-bit vector {c} equals the XOR of the position indices of all data bits that are 1.
- Injection: out_code = clean codeword XOR the in_inj_mask captured with the same word. The mask is never folded into the parity calculation.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - in_data and in_inj_mask are don't-care when in_valid=0.
  - out_code is held stable while out_valid=1 && out_ready=0.
- PIPE=1:
  - One output register. in_ready = !out_valid || out_ready.
  - Latency is 1 cycle from input transfer to out_valid.
  - Full throughput with simultaneous in and out transfers.
- PIPE=2:
  - Stage 1 registers data, mask and check bits. Stage 2 registers the final codeword.
  - Each stage advances when its successor is empty or is transferring that cycle. in_ready = stage-1 empty or stage-1 advancing.
  - Latency is 2 cycles, one word per cycle sustained, no bubbles inserted under continuous out_ready.
- No word is dropped or duplicated under any in_valid/out_ready pattern. Output order equals input order.
- enc_count:
  - Increments by 1 on each output transfer and wraps modulo 2^CNT_W to 0.
  - Holds value otherwise. Not affected by injection.
- Reset mid-operation: in-flight words are discarded and enc_count returns to 0. No spurious out_valid follows reset release.

Test Plan:
- DATA_W=11, PIPE=1, out_ready=1; in_data = 0x000, 0x001, 0x002, 0x400, 0x7FF with mask 0. Required out_code one cycle later: 0x0000, 0x000F, 0x0033, 0x8117, 0xFFFF. enc_count=5 afterwards.
- Injection: in_data=0x001, in_inj_mask=0x0008 -> out_code=0x0007. in_inj_mask=0x8001 with in_data=0x000 -> out_code=0x8001.
- Backpressure, PIPE=2:
  - Stream 0x001..0x00A with out_ready low for cycles 3-6.
  - in_ready must drop once both stages are full, and out_code must hold stable while stalled.
  - All 10 codewords must arrive in order, with enc_count=10.
  - With out_ready held high, first output must appear 2 cycles after first input, then one per cycle.
- Counter wrap: CNT_W=4; send 17 words -> enc_count reads 15 after the 15th transfer, 0 after the 16th, 1 after the 17th.
- Reset mid-stream: PIPE=2 with both stages full, pulse rst_n low asynchronously between edges.
  - out_valid=0 and enc_count=0 immediately.
  - No stale word is emitted after release.
  - Next input 0x002 yields 0x0033.
- Self-check sweep: DATA_W=11 over all 2048 inputs with random in_valid/out_ready. The scoreboard recomputes check bits and overall parity and verifies that XOR of positions of set bits is 0 and total popcount is even.

Source files
------------

// File: rtl/hamming_secded_encoder_pipe.sv
// -----------------------------------------------------------------------------
// hamming_secded_encoder_pipe
//
// Parametrised SECDED Hamming encoder with a valid/ready stream interface.
// Check bits are computed arithmetically for any DATA_W. The pipeline is one
// or two register stages deep. An XOR mask captured with each word is applied
// to the finished codeword so decoder benches can be fed corrupted words
// directly.
//
// Codeword layout (positions 0..CW_W-1):
//   0                  overall even parity over positions 1..CW_W-1
//   1, 2, 4, ...       check bits c0..c(PAR_W-1)
//   all other          data bits in ascending order, in_data[0] lowest
// The check-bit vector equals the XOR of the positions of all set data bits.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     input word valid
//   in_ready     encoder can accept a word this cycle
//   in_data      data word [DATA_W]
//   in_inj_mask  XOR mask applied to the codeword [CW_W]; zero = clean
//   out_valid    codeword valid
//   out_ready    downstream accepts the codeword
//   out_code     encoded codeword after mask [CW_W]
//   enc_count    codewords handed off downstream, wraps [CNT_W]
// -----------------------------------------------------------------------------
module hamming_secded_encoder_pipe #(
    parameter int DATA_W = 11,
    parameter int PIPE   = 1,
    parameter int CNT_W  = 16,
    // Smallest r with 2^r >= DATA_W + r + 1, for the legal range 4..57.
    localparam int PAR_W = (DATA_W <= 4)  ? 3 :
                           (DATA_W <= 11) ? 4 :
                           (DATA_W <= 26) ? 5 : 6,
    localparam int CW_W  = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CW_W-1:0]   in_inj_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   out_code,
    output logic [CNT_W-1:0]  enc_count
);

    // XOR of the positions of all set data bits; data fills the
    // non-power-of-two positions in ascending order.
    function automatic logic [PAR_W-1:0] calcCheck(input logic [DATA_W-1:0] data);
        logic [PAR_W-1:0] chk;
        int               dIdx;
        chk  = '0;
        dIdx = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (data[dIdx]) begin
                    chk = chk ^ PAR_W'(pos);
                end
                dIdx++;
            end
        end
        return chk;
    endfunction

    // Scatter data and check bits into their positions, then add overall
    // parity at position 0. The injection mask is applied by the caller so
    // it never influences the parity.
    function automatic logic [CW_W-1:0] buildCode(input logic [DATA_W-1:0] data,
                                                  input logic [PAR_W-1:0]  chk);
        logic [CW_W-1:0] code;
        int              dIdx;
        int              cIdx;
        code = '0;
        dIdx = 0;
        cIdx = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) == 0) begin
                code[pos] = chk[cIdx];
                cIdx++;
            end else begin
                code[pos] = data[dIdx];
                dIdx++;
            end
        end
        code[0] = ^code[CW_W-1:1];
        return code;
    endfunction

    logic            outValid;
    logic [CW_W-1:0] outCode;
    logic [CNT_W-1:0] encCount;
    logic            outXfer;

    assign outXfer   = outValid && out_ready;
    assign out_valid = outValid;
    assign out_code  = outCode;
    assign enc_count = encCount;

    generate
        if (PIPE == 1) begin : gPipe1
            // Single output register: accept whenever it is empty or draining.
            assign in_ready = !outValid || out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    outValid <= 1'b0;
                    // NOTE: the codeword register is reset as well so out_code
                    // reads 0 during reset rather than whatever was in flight.
                    outCode  <= '0;
                end else if (in_valid && in_ready) begin
                    outValid <= 1'b1;
                    outCode  <= buildCode(in_data, calcCheck(in_data)) ^ in_inj_mask;
                end else if (out_ready) begin
                    outValid <= 1'b0;
                end
            end
        end else begin : gPipe2
            logic              s1Valid;
            logic [DATA_W-1:0] s1Data;
            logic [CW_W-1:0]   s1Mask;
            logic [PAR_W-1:0]  s1Check;
            logic              s2Free;
            logic              s1Advance;

            // Stage 2 can take a word if empty or handing its word off now;
            // stage 1 can take a word if empty or moving into stage 2 now.
            assign s2Free    = !outValid || out_ready;
            assign s1Advance = s1Valid && s2Free;
            assign in_ready  = !s1Valid || s2Free;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1Valid <= 1'b0;
                    s1Data  <= '0;
                    s1Mask  <= '0;
                    s1Check <= '0;
                end else if (in_valid && in_ready) begin
                    s1Valid <= 1'b1;
                    s1Data  <= in_data;
                    s1Mask  <= in_inj_mask;
                    s1Check <= calcCheck(in_data);
                end else if (s1Advance) begin
                    s1Valid <= 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    outValid <= 1'b0;
                    outCode  <= '0;
                end else if (s1Advance) begin
                    outValid <= 1'b1;
                    outCode  <= buildCode(s1Data, s1Check) ^ s1Mask;
                end else if (out_ready) begin
                    outValid <= 1'b0;
                end
            end
        end
    endgenerate

    // Counts output handshakes only; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            encCount <= '0;
        end else if (outXfer) begin
            // NOTE: non-blocking assignment so every flop samples pre-edge
            // values regardless of process evaluation order.
            encCount <= encCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_secded_encoder_pipe.sv
// -----------------------------------------------------------------------------
// tb_hamming_secded_encoder_pipe
//
// Two encoder instances share clock and reset:
//   dutA  PIPE=1, CNT_W=4   directed vectors, injection, counter wrap
//   dutB  PIPE=2, CNT_W=16  backpressure, latency/throughput, sweep, reset
// Expected codewords are pushed to a per-instance queue when a word is
// accepted and popped by a negedge monitor when the DUT hands one off.
// -----------------------------------------------------------------------------
module tb_hamming_secded_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        inValidA, inReadyA, outValidA, outReadyA;
    logic [10:0] inDataA;
    logic [15:0] inMaskA, outCodeA;
    logic [3:0]  encCountA;

    logic        inValidB, inReadyB, outValidB, outReadyB;
    logic [10:0] inDataB;
    logic [15:0] inMaskB, outCodeB;
    logic [15:0] encCountB;

    int          checks = 0;
    int          errors = 0;

    logic [15:0] qA[$];
    logic [15:0] qB[$];

    int          readyModeB = 0;
    int          streamCyc  = 0;
    bit          sawBlockB  = 1'b0;
    bit          stallB     = 1'b0;
    logic [15:0] holdB      = '0;

    always #5 clk = ~clk;

    hamming_secded_encoder_pipe #(.DATA_W(11), .PIPE(1), .CNT_W(4)) dutA (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (inValidA),
        .in_ready    (inReadyA),
        .in_data     (inDataA),
        .in_inj_mask (inMaskA),
        .out_valid   (outValidA),
        .out_ready   (outReadyA),
        .out_code    (outCodeA),
        .enc_count   (encCountA)
    );

    hamming_secded_encoder_pipe #(.DATA_W(11), .PIPE(2), .CNT_W(16)) dutB (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (inValidB),
        .in_ready    (inReadyB),
        .in_data     (inDataB),
        .in_inj_mask (inMaskB),
        .out_valid   (outValidB),
        .out_ready   (outReadyB),
        .out_code    (outCodeB),
        .enc_count   (encCountB)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder built from an explicit table of data positions.
    function automatic logic [15:0] refEncode(input logic [10:0] d);
        int          dpos [11];
        logic [15:0] cw;
        logic [3:0]  syn;
        dpos = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        cw   = '0;
        syn  = '0;
        for (int j = 0; j < 11; j++) begin
            if (d[j]) begin
                cw[dpos[j]] = 1'b1;
                syn         = syn ^ 4'(dpos[j]);
            end
        end
        cw[1] = syn[0];
        cw[2] = syn[1];
        cw[4] = syn[2];
        cw[8] = syn[3];
        cw[0] = ^cw;
        return cw;
    endfunction

    // A clean SECDED codeword has zero syndrome and even weight.
    function automatic bit syndromeOk(input logic [15:0] cw);
        logic [3:0] s;
        s = '0;
        for (int p = 0; p < 16; p++) begin
            if (cw[p]) s = s ^ 4'(p);
        end
        return (s == 4'd0) && (^cw == 1'b0);
    endfunction

    // out_ready pattern generator for dutB.
    always @(posedge clk) begin
        #1;
        streamCyc++;
        case (readyModeB)
            1:       outReadyB = 1'($urandom_range(0, 1));
            2:       outReadyB = !(streamCyc >= 3 && streamCyc <= 6);
            3:       outReadyB = 1'b0;
            default: outReadyB = 1'b1;
        endcase
    end

    // Output monitors.
    always @(negedge clk) begin
        if (rst_n) begin
            if (outValidA && outReadyA) begin
                if (qA.size() == 0) begin
                    check("spuriousA", 32'(outValidA), 32'(0));
                end else begin
                    check("codeA", 32'(outCodeA), 32'(qA.pop_front()));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (stallB && outValidB) begin
                check("holdB", 32'(outCodeB), 32'(holdB));
            end
            stallB = outValidB && !outReadyB;
            holdB  = outCodeB;
            if (outValidB && outReadyB) begin
                if (qB.size() == 0) begin
                    check("spuriousB", 32'(outValidB), 32'(0));
                end else begin
                    check("codeB", 32'(outCodeB), 32'(qB.pop_front()));
                    check("syndromeB", 32'(syndromeOk(outCodeB)), 32'(1));
                end
            end
            if (!inReadyB) sawBlockB = 1'b1;
        end
    end

    // Drive one word, wait for acceptance, queue its expected codeword.
    // Called and returns at posedge+1.
    task automatic pushA(input logic [10:0] d, input logic [15:0] m, input logic [15:0] exp);
        int n = 0;
        inValidA = 1'b1;
        inDataA  = d;
        inMaskA  = m;
        @(negedge clk);
        while (!inReadyA && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("timeoutA", 32'(n), 32'(0));
        @(posedge clk);
        #1;
        qA.push_back(exp);
        inValidA = 1'b0;
    endtask

    task automatic pushB(input logic [10:0] d, input logic [15:0] m, input logic [15:0] exp);
        int n = 0;
        inValidB = 1'b1;
        inDataB  = d;
        inMaskB  = m;
        @(negedge clk);
        while (!inReadyB && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("timeoutB", 32'(n), 32'(0));
        @(posedge clk);
        #1;
        qB.push_back(exp);
        inValidB = 1'b0;
    endtask

    task automatic drainA();
        int n = 0;
        while (qA.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drainA", 32'(qA.size()), 32'(0));
    endtask

    task automatic drainB();
        int n = 0;
        while (qB.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drainB", 32'(qB.size()), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        inValidA  = 1'b0; inDataA = '0; inMaskA = '0; outReadyA = 1'b1;
        inValidB  = 1'b0; inDataB = '0; inMaskB = '0; outReadyB = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        check("rstValidA", 32'(outValidA), 32'(0));
        check("rstCodeA",  32'(outCodeA),  32'(0));
        check("rstCountA", 32'(encCountA), 32'(0));
        check("rstValidB", 32'(outValidB), 32'(0));
        check("rstCodeB",  32'(outCodeB),  32'(0));
        check("rstCountB", 32'(encCountB), 32'(0));
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("readyA", 32'(inReadyA), 32'(1));
        check("readyB", 32'(inReadyB), 32'(1));

        // ---- dutA: directed vectors, one-cycle latency ----
        pushA(11'h000, 16'h0000, 16'h0000);
        check("latencyA", 32'(outValidA), 32'(1));
        pushA(11'h001, 16'h0000, 16'h000F);
        pushA(11'h002, 16'h0000, 16'h0033);
        pushA(11'h400, 16'h0000, 16'h8117);
        pushA(11'h7FF, 16'h0000, 16'hFFFF);
        drainA();
        check("count5A", 32'(encCountA), 32'(5));

        // ---- dutA: injection ----
        pushA(11'h001, 16'h0008, 16'h0007);
        pushA(11'h000, 16'h8001, 16'h8001);
        drainA();
        check("count7A", 32'(encCountA), 32'(7));

        // ---- dutA: counter wrap at 4 bits (transfers 8..17) ----
        for (int i = 8; i <= 17; i++) begin
            logic [10:0] d;
            d = 11'($urandom_range(0, 2047));
            pushA(d, 16'h0000, refEncode(d));
            drainA();
            check("wrapA", 32'(encCountA), 32'(i % 16));
        end

        // ---- dutB: backpressure, out_ready low for cycles 3-6 ----
        sawBlockB  = 1'b0;
        streamCyc  = 0;
        readyModeB = 2;
        for (int i = 1; i <= 10; i++) begin
            pushB(11'(i), 16'h0000, refEncode(11'(i)));
        end
        drainB();
        check("blockB", 32'(sawBlockB), 32'(1));
        check("count10B", 32'(encCountB), 32'(10));

        // ---- dutB: two-cycle latency, one word per cycle ----
        readyModeB = 0;
        @(posedge clk);
        #1;
        inValidB = 1'b1;
        inMaskB  = '0;
        for (int k = 0; k < 4; k++) begin
            inDataB = 11'(k * 37 + 5);
            check("acceptB", 32'(inReadyB), 32'(1));
            @(posedge clk);
            #1;
            qB.push_back(refEncode(inDataB));
            check("pipeValidB", 32'(outValidB), 32'((k == 0) ? 0 : 1));
        end
        inValidB = 1'b0;
        @(posedge clk);
        #1;
        check("pipeValidB", 32'(outValidB), 32'(1));
        drainB();
        check("count14B", 32'(encCountB), 32'(14));

        // ---- dutB: exhaustive sweep with random valid/ready ----
        readyModeB = 1;
        for (int i = 0; i < 2048; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            pushB(11'(i), 16'h0000, refEncode(11'(i)));
        end
        drainB();
        check("countSweepB", 32'(encCountB), 32'(2062));

        // ---- dutB: asynchronous reset with both stages full ----
        readyModeB = 3;
        @(posedge clk);
        #1;
        pushB(11'h123, 16'h0000, refEncode(11'h123));
        pushB(11'h456, 16'h0000, refEncode(11'h456));
        check("fullB", 32'(inReadyB), 32'(0));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("asyncValidB", 32'(outValidB), 32'(0));
        check("asyncCountB", 32'(encCountB), 32'(0));
        qB.delete();
        qA.delete();
        #1 rst_n = 1'b1;
        readyModeB = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("noStaleB", 32'(outValidB), 32'(0));
        end
        pushB(11'h002, 16'h0000, 16'h0033);
        drainB();
        check("countAfterRstB", 32'(encCountB), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
